// File: rtl/pattern_stream_source.sv
// pattern_stream_source: byte-stream source and ack responder for the
// "boab" pattern detector. It emits filler bytes followed by the pattern,
// waits for the detector flag, clears it by toggling ack, and counts hits.
// Optional build macro DECOY_EN: sends a "boax" decoy before every real
// pattern, then watches for a false detection during DECOY_CHK.
module pattern_stream_source #(
    parameter logic [7:0] FILLER       = 8'h2E,
    parameter int         GAP          = 4,
    parameter int         NUM_PATTERNS = 8,
    parameter int         TIMEOUT      = 16,
    parameter int         ACK_DELAY    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       found_pattern,
    output logic [7:0] data,
    output logic       ack,
    output logic       busy,
    output logic [7:0] hit_count,
    output logic       timeout_err,
`ifdef DECOY_EN
    output logic       false_hit,
`endif
    output logic       done
);

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] NPAT     = 8'(NUM_PATTERNS);
    // The WAIT_HIT cycle that saw the flag plus the first ACK_DLY cycle
    // already account for two cycles of found_pattern being held high.
    localparam logic [7:0] AD_HOLD  = (ACK_DELAY > 2) ? 8'(ACK_DELAY - 2) : 8'd0;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
`ifdef DECOY_EN
        DECOY,
        DECOY_CHK,
`endif
        PAT,
        WAIT_HIT,
        ACK_DLY,
        WAIT_CLR,
        NEXT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;     // per-state cycle counter, cleared on every state entry
    logic [7:0] sent_q, sent_d;   // patterns sent in this run
    logic       ack_q, ack_d;
    logic [7:0] hit_q, hit_d;
    logic       to_q, to_d;
    logic       done_q, done_d;
`ifdef DECOY_EN
    logic       fh_q, fh_d;
    assign false_hit = fh_q;
`endif

    assign ack         = ack_q;
    assign busy        = (state_q != IDLE);
    assign hit_count   = hit_q;
    assign timeout_err = to_q;
    assign done        = done_q;

    // Byte on the bus is a pure function of the current state and position.
    always_comb begin
        data = FILLER;
        case (state_q)
            PAT: begin
                case (cnt_q[1:0])
                    2'd0:    data = 8'd98;
                    2'd1:    data = 8'd111;
                    2'd2:    data = 8'd97;
                    default: data = 8'd98;
                endcase
            end
`ifdef DECOY_EN
            DECOY: begin
                case (cnt_q[1:0])
                    2'd0:    data = 8'd98;
                    2'd1:    data = 8'd111;
                    2'd2:    data = 8'd97;
                    default: data = 8'd120;
                endcase
            end
`endif
            default: data = FILLER;
        endcase
    end

    // Next-state and register updates for the run sequencer.
    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        ack_d   = ack_q;
        hit_d   = hit_q;
        to_d    = to_q;
        done_d  = 1'b0;
`ifdef DECOY_EN
        fh_d    = fh_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    hit_d   = '0;
                    to_d    = 1'b0;
                    sent_d  = '0;
`ifdef DECOY_EN
                    fh_d    = 1'b0;
`endif
                    state_d = FILL;
                end
            end
            FILL: begin
                if (cnt_q == GAP_LAST) begin
`ifdef DECOY_EN
                    state_d = DECOY;
`else
                    state_d = PAT;
`endif
                end
            end
`ifdef DECOY_EN
            DECOY: begin
                if (cnt_q == 8'd3) state_d = DECOY_CHK;
            end
            DECOY_CHK: begin
                if (found_pattern) fh_d = 1'b1;
                if (cnt_q == TO_LAST) state_d = PAT;
            end
`endif
            PAT: begin
                if (cnt_q == 8'd3) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = WAIT_HIT;
                end
            end
            WAIT_HIT: begin
                if (found_pattern) begin
                    state_d = ACK_DLY;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = NEXT;
                end
            end
            ACK_DLY: begin
                if (!found_pattern) begin
                    state_d = NEXT;
                end else if (cnt_q >= AD_HOLD) begin
                    ack_d   = ~ack_q;
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!found_pattern) begin
                    if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
                    state_d = NEXT;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (sent_q == NPAT) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sent_q  <= '0;
            ack_q   <= 1'b0;
            hit_q   <= '0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef DECOY_EN
            fh_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            ack_q   <= ack_d;
            hit_q   <= hit_d;
            to_q    <= to_d;
            done_q  <= done_d;
`ifdef DECOY_EN
            fh_q    <= fh_d;
`endif
        end
    end

endmodule
